// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_timing_pkg
// Description : Shared types and constants for the VGA raster timing generator.
//               Axis FSM state type, default 640x480@60 timing, counter widths
//               and small helpers for the per-axis segment sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Segment of one raster axis (horizontal pixels or vertical lines).
  typedef enum logic [1:0] {
    S_ACT  = 2'd0,
    S_FP   = 2'd1,
    S_SYNC = 2'd2,
    S_BP   = 2'd3
  } axis_state_t;

  // Default 640x480@60 Hz timing (25.175 MHz pixel clock).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Counter widths; also the widths of pix_x / pix_y.
  localparam int H_CNT_W   = 11;
  localparam int V_CNT_W   = 10;
  localparam int H_TOT_MAX = 2047;
  localparam int V_TOT_MAX = 1023;

  // Segment order: ACT -> FP -> SYNC -> BP -> ACT.
  function automatic axis_state_t next_state(input axis_state_t st);
    axis_state_t r;
    case (st)
      S_ACT:   r = S_FP;
      S_FP:    r = S_SYNC;
      S_SYNC:  r = S_BP;
      default: r = S_ACT;
    endcase
    return r;
  endfunction

  // Length of the given segment in counter units.
  function automatic int seg_len(input axis_state_t st, input int act,
                                 input int fp, input int sync, input int bp);
    int r;
    case (st)
      S_ACT:   r = act;
      S_FP:    r = fp;
      S_SYNC:  r = sync;
      default: r = bp;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Interface   : vga_timing_gen_if
// Description : Control inputs and video timing outputs of vga_timing_gen.
//   enable       run raster; low holds the generator idle
//   force_blank  frame-blank request (asynchronous to clk)
//   h_sync       horizontal sync
//   v_sync       vertical sync
//   blank_n      1 = active video
//   pix_x/pix_y  current column / row
//   line_start   1-cycle pulse on x=0
//   frame_start  1-cycle pulse on (0,0)
//   master : the timing generator; slave : the consumer/controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic               enable;
  logic               force_blank;
  logic               h_sync;
  logic               v_sync;
  logic               blank_n;
  logic [H_CNT_W-1:0] pix_x;
  logic [V_CNT_W-1:0] pix_y;
  logic               line_start;
  logic               frame_start;

  modport master (
    input  enable, force_blank,
    output h_sync, v_sync, blank_n, pix_x, pix_y, line_start, frame_start
  );

  modport slave (
    output enable, force_blank,
    input  h_sync, v_sync, blank_n, pix_x, pix_y, line_start, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: segment FSM (ACT/FP/SYNC/BP) with a segment
//               counter reloaded on each state change, plus a position counter
//               running 0..TOT-1.
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   hold_i     in   force state ACT and counters to 0
//   advance_i  in   step one unit (pixel or line)
//   pos_o      out  position 0..TOT-1
//   state_o    out  current segment
//   wrap_o     out  this advance returns pos to 0
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = H_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         hold_i,
  input  logic         advance_i,
  output logic [W-1:0] pos_o,
  output axis_state_t  state_o,
  output logic         wrap_o
);

  localparam int            TOT      = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0]  POS_LAST = W'(TOT - 1);
  localparam logic [W-1:0]  ONE      = W'(1);

  axis_state_t  state_q, state_d;
  logic [W-1:0] seg_q, seg_d;
  logic [W-1:0] pos_q, pos_d;
  logic         seg_last;
  logic         pos_last;

  assign seg_last = (seg_q == W'(seg_len(state_q, ACTIVE, FP, SYNC, BP) - 1));
  assign pos_last = (pos_q == POS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_ACT;
      seg_q   <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    pos_d   = pos_q;
    if (hold_i) begin
      state_d = S_ACT;
      seg_d   = '0;
      pos_d   = '0;
    end else if (advance_i) begin
      pos_d = pos_last ? '0 : pos_q + ONE;
      if (seg_last) begin
        state_d = next_state(state_q);
        seg_d   = '0;
      end else begin
        seg_d = seg_q + ONE;
      end
    end
  end

  assign pos_o   = pos_q;
  assign state_o = state_q;
  assign wrap_o  = advance_i & ~hold_i & pos_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-clock VGA raster timing generator. Two axis counters
//               (horizontal per pixel, vertical per line wrap), a force_blank
//               synchronizer latched once per frame, enable gating and a
//               registered output stage lagging the counters by one clock.
//   clk      in  pixel clock
//   reset_n  in  asynchronous active-low reset
//   vga      master modport: enable, force_blank in; h_sync, v_sync,
//            blank_n, pix_x, pix_y, line_start, frame_start out
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 ||
        V_BP < 1 || H_TOT > H_TOT_MAX || V_TOT > V_TOT_MAX) begin : g_param_check
      $error("vga_timing_gen: porch/sync must be >= 1 and totals must fit the counters");
    end
  endgenerate

  logic               hold;
  logic [H_CNT_W-1:0] h_pos;
  logic [V_CNT_W-1:0] v_pos;
  axis_state_t        h_state, v_state;
  logic               h_wrap, v_wrap;

  assign hold = ~vga.enable;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (H_CNT_W)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold_i    (hold),
    .advance_i (1'b1),
    .pos_o     (h_pos),
    .state_o   (h_state),
    .wrap_o    (h_wrap)
  );

  // The vertical axis steps once per line, on the horizontal wrap cycle;
  // its wrap therefore marks the last pixel of the frame.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (V_CNT_W)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold_i    (hold),
    .advance_i (h_wrap),
    .pos_o     (v_pos),
    .state_o   (v_state),
    .wrap_o    (v_wrap)
  );

  // force_blank: 2-FF synchronizer, sampled into fb_frame only on the frame
  // wrap so a whole frame is either blanked or not.
  logic fb_sync1_q, fb_sync2_q;
  logic fb_frame_q, fb_frame_d;

  assign fb_frame_d = v_wrap ? fb_sync2_q : fb_frame_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_sync1_q <= 1'b0;
      fb_sync2_q <= 1'b0;
      fb_frame_q <= 1'b0;
    end else begin
      fb_sync1_q <= vga.force_blank;
      fb_sync2_q <= fb_sync1_q;
      fb_frame_q <= fb_frame_d;
    end
  end

  // Output stage: one clock behind the counters, reset values while idle.
  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic               blank_n_q, blank_n_d;
  logic [H_CNT_W-1:0] pix_x_q, pix_x_d;
  logic [V_CNT_W-1:0] pix_y_q, pix_y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  always_comb begin
    h_sync_d      = ~SYNC_POL;
    v_sync_d      = ~SYNC_POL;
    blank_n_d     = 1'b0;
    pix_x_d       = '0;
    pix_y_d       = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (vga.enable) begin
      h_sync_d      = (h_state == S_SYNC) ? SYNC_POL : ~SYNC_POL;
      v_sync_d      = (v_state == S_SYNC) ? SYNC_POL : ~SYNC_POL;
      blank_n_d     = (h_state == S_ACT) && (v_state == S_ACT) && !fb_frame_q;
      pix_x_d       = h_pos;
      pix_y_d       = v_pos;
      line_start_d  = (h_pos == '0);
      frame_start_d = (h_pos == '0) && (v_pos == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      blank_n_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      blank_n_q     <= blank_n_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.h_sync      = h_sync_q;
  assign vga.v_sync      = v_sync_q;
  assign vga.blank_n     = blank_n_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
`default_nettype wire
